fx2_host_emu: RTL and testbench

- Synthesizable stand-in for the FX2LP side of the FX2 comm protocol. It drives the FIFO-side pins of the FPGA comm block from an on-chip command/stream interface.
- Lets an on-chip master (UART bridge, soft CPU, test sequencer) issue channel reads/writes through the unmodified comm block.
- Generates the header byte, the 4-byte big-endian count and the OUT-FIFO data.
- Sinks IN-FIFO data and observes the packet-end strobe.

---
 rtl/fx2_host_emu_if.sv | 57 +++++
 rtl/fx2_host_emu.sv | 160 ++++++++++++++++
 tb/tb_fx2_host_emu.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx2_host_emu_if.sv
// Bus bundle for fx2_host_emu: the FX2 FIFO-side pins facing the comm block,
// plus the on-chip command / payload streams facing the local master.
// The slave modport is the emulator's view; the master modport is the view of
// whatever drives it (comm block + local master together).
// Optional: FX2_ALIGN_CHECK_EN adds protoErr_out.
interface fx2_host_emu_if;
    logic        fx2FifoSel_in;
    logic [7:0]  fx2Data_in;
    logic [7:0]  fx2Data_out;
    logic        fx2DataOe_out;
    logic        fx2Read_in;
    logic        fx2GotData_out;
    logic        fx2Write_in;
    logic        fx2GotRoom_out;
    logic        fx2PktEnd_in;
    logic        cmdValid_in;
    logic        cmdReady_out;
    logic        cmdIsRead_in;
    logic [6:0]  cmdChan_in;
    logic [31:0] cmdCount_in;
    logic [7:0]  wrData_in;
    logic        wrValid_in;
    logic        wrReady_out;
    logic [7:0]  rdData_out;
    logic        rdValid_out;
    logic        rdReady_in;
    logic        busy_out;
    logic        pktEnd_out;
    logic        errZero_out;
`ifdef FX2_ALIGN_CHECK_EN
    logic        protoErr_out;
`endif

    modport slave (
        input  fx2FifoSel_in, fx2Data_in, fx2Read_in, fx2Write_in, fx2PktEnd_in,
        input  cmdValid_in, cmdIsRead_in, cmdChan_in, cmdCount_in,
        input  wrData_in, wrValid_in, rdReady_in,
        output fx2Data_out, fx2DataOe_out, fx2GotData_out, fx2GotRoom_out,
        output cmdReady_out, wrReady_out, rdData_out, rdValid_out,
        output busy_out, pktEnd_out, errZero_out
`ifdef FX2_ALIGN_CHECK_EN
        , output protoErr_out
`endif
    );

    modport master (
        output fx2FifoSel_in, fx2Data_in, fx2Read_in, fx2Write_in, fx2PktEnd_in,
        output cmdValid_in, cmdIsRead_in, cmdChan_in, cmdCount_in,
        output wrData_in, wrValid_in, rdReady_in,
        input  fx2Data_out, fx2DataOe_out, fx2GotData_out, fx2GotRoom_out,
        input  cmdReady_out, wrReady_out, rdData_out, rdValid_out,
        input  busy_out, pktEnd_out, errZero_out
`ifdef FX2_ALIGN_CHECK_EN
        , input protoErr_out
`endif
    );
endinterface

// File: rtl/fx2_host_emu.sv
// FX2LP host emulator: sources header / big-endian count / payload into the
// comm block's OUT FIFO pins and sinks its IN FIFO pins into a 1-entry
// output register. Optional macro FX2_ALIGN_CHECK_EN adds a packet-end
// alignment check (protoErr_out) in the tail cycle of a read.
module fx2_host_emu #(
    parameter int ALIGN_BYTES = 512
) (
    input  logic          clk_in,
    input  logic          reset_in,
    fx2_host_emu_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_CNT, S_SEND, S_RECV, S_TAIL} state_t;

    // Only meaningful as a power-of-two block size.
    generate
        if ((ALIGN_BYTES < 2) || ((ALIGN_BYTES & (ALIGN_BYTES - 1)) != 0)) begin : g_bad_align
            $error("ALIGN_BYTES must be a power of two");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [7:0]  pend_q;
    logic        pend_valid_q;
    logic [2:0]  idx_q;
    logic [31:0] rem_q;
    logic        is_read_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        pkt_end_q;
    logic        err_zero_q;

    logic        out_xfer, in_xfer, cmd_start, cmd_zero, wr_fire, last_byte;
    logic        cmd_ready, busy, wr_ready, got_room;
    logic [7:0]  cnt_byte [4];

    // Byte lanes of the count, lane 3 = MSB; rem_q still holds the full count in S_CNT.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_lane
        assign cnt_byte[gi] = rem_q[8*gi +: 8];
    end

    assign out_xfer  = !bus.fx2FifoSel_in && pend_valid_q && !bus.fx2Read_in;
    assign in_xfer   = bus.fx2FifoSel_in && got_room && !bus.fx2Write_in;
    assign cmd_start = (state_q == S_IDLE) && bus.cmdValid_in && (bus.cmdCount_in != 32'd0);
    assign cmd_zero  = (state_q == S_IDLE) && bus.cmdValid_in && (bus.cmdCount_in == 32'd0);
    assign wr_fire   = bus.wrValid_in && wr_ready;
    assign last_byte = (rem_q == 32'd1);

    // State register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_start) state_d = S_CNT;
            S_CNT:  if (out_xfer && idx_q == 3'd4) state_d = is_read_q ? S_RECV : S_SEND;
            S_SEND: if (out_xfer && last_byte) state_d = S_IDLE;
            S_RECV: if (in_xfer && last_byte) state_d = S_TAIL;
            S_TAIL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs; a write byte is taken only while unloaded bytes remain.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        got_room  = (state_q == S_RECV) && (bus.rdReady_in || !rd_valid_q);
        wr_ready  = (state_q == S_SEND) && (rem_q > {31'd0, pend_valid_q})
                    && (!pend_valid_q || out_xfer);
    end

    // Holding register, counters, output register and event pulses.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            pend_q       <= 8'h00;
            pend_valid_q <= 1'b0;
            idx_q        <= 3'd0;
            rem_q        <= 32'd0;
            is_read_q    <= 1'b0;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            pkt_end_q    <= 1'b0;
            err_zero_q   <= 1'b0;
        end else begin
            pkt_end_q  <= !bus.fx2PktEnd_in;
            err_zero_q <= cmd_zero;
            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        pend_q       <= {bus.cmdIsRead_in, bus.cmdChan_in};
                        pend_valid_q <= 1'b1;
                        idx_q        <= 3'd0;
                        rem_q        <= bus.cmdCount_in;
                        is_read_q    <= bus.cmdIsRead_in;
                    end
                end
                S_CNT: begin
                    if (out_xfer) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd4) pend_valid_q <= 1'b0;
                        else               pend_q <= cnt_byte[~idx_q[1:0]];
                    end
                end
                S_SEND: begin
                    if (wr_fire) begin
                        pend_q       <= bus.wrData_in;
                        pend_valid_q <= 1'b1;
                    end else if (out_xfer) begin
                        pend_valid_q <= 1'b0;
                    end
                    if (out_xfer && rem_q != 32'd0) rem_q <= rem_q - 32'd1;
                end
                S_RECV: begin
                    if (in_xfer && rem_q != 32'd0) rem_q <= rem_q - 32'd1;
                end
                default: ;
            endcase
            if (in_xfer) begin
                rd_data_q  <= bus.fx2Data_in;
                rd_valid_q <= 1'b1;
            end else if (rd_valid_q && bus.rdReady_in) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

`ifdef FX2_ALIGN_CHECK_EN
    localparam int ALIGN_W = $clog2(ALIGN_BYTES);
    logic [ALIGN_W-1:0] align_q;
    logic               proto_err_q;

    // Packet end is expected exactly when the count is not a block multiple.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            align_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (cmd_start) align_q <= bus.cmdCount_in[ALIGN_W-1:0];
            proto_err_q <= (state_q == S_TAIL) && ((align_q != '0) != !bus.fx2PktEnd_in);
        end
    end
    assign bus.protoErr_out = proto_err_q;
`endif

    assign bus.fx2Data_out    = pend_q;
    assign bus.fx2GotData_out = pend_valid_q;
    assign bus.fx2DataOe_out  = !bus.fx2FifoSel_in && pend_valid_q;
    assign bus.fx2GotRoom_out = got_room;
    assign bus.cmdReady_out   = cmd_ready;
    assign bus.busy_out       = busy;
    assign bus.wrReady_out    = wr_ready;
    assign bus.rdData_out     = rd_data_q;
    assign bus.rdValid_out    = rd_valid_q;
    assign bus.pktEnd_out     = pkt_end_q;
    assign bus.errZero_out    = err_zero_q;
endmodule

// File: tb/tb_fx2_host_emu.sv
// Bench for fx2_host_emu: emulates the comm block on the FIFO pins and the
// local master on the command/payload streams; queues hold expected bytes.
module tb_fx2_host_emu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fx2_host_emu_if bus();
    fx2_host_emu #(.ALIGN_BYTES(512)) dut (.clk_in(clk), .reset_in(rst_n), .bus(bus));

    typedef struct {
        logic        rd;
        logic [6:0]  chan;
        logic [31:0] cnt;
        logic [7:0]  base;
        logic [7:0]  step;
        logic        pkt;
        logic        missel;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] exp_out[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wr_q[$];
    logic [7:0] in_src[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  pe_state = 0;
    int  pkt_cnt = 0, zero_cnt = 0, proto_cnt = 0;
    bit  tail_pkt = 0, mis_sel = 0, rd_en = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Comm block: drains OUT bytes, pushes IN bytes, optionally strobes packet end.
    initial begin
        bus.fx2FifoSel_in = 0; bus.fx2Read_in = 1; bus.fx2Write_in = 1;
        bus.fx2PktEnd_in = 1; bus.fx2Data_in = 0;
        forever begin
            @(negedge clk);
            if (pe_state == 1) begin bus.fx2PktEnd_in = 0; pe_state = 2; end
            else if (pe_state == 2) begin bus.fx2PktEnd_in = 1; pe_state = 0; end
            bus.fx2Read_in = 1; bus.fx2Write_in = 1; bus.fx2FifoSel_in = 0;
            if (bus.fx2GotData_out) begin
                if (mis_sel && $urandom_range(0, 2) == 0) begin
                    bus.fx2FifoSel_in = 1; bus.fx2Read_in = 0; #1;
                    check("oe_missel", {31'd0, bus.fx2DataOe_out}, 32'd0);
                end else begin
                    bus.fx2Read_in = 0; #1;
                    check("oe_out", {31'd0, bus.fx2DataOe_out}, 32'd1);
                    if (exp_out.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL out_unexpected: got %0h expected none", bus.fx2Data_out);
                    end else begin
                        check("out_byte", {24'd0, bus.fx2Data_out}, {24'd0, exp_out.pop_front()});
                    end
                end
            end else if (in_src.size() > 0) begin
                bus.fx2FifoSel_in = 1; bus.fx2Write_in = 0; bus.fx2Data_in = in_src[0]; #1;
                if (bus.fx2GotRoom_out) begin
                    void'(in_src.pop_front());
                    if (in_src.size() == 0 && tail_pkt) pe_state = 1;
                end
            end
        end
    end

    // Local master, write side.
    initial begin
        bus.wrValid_in = 0; bus.wrData_in = 0;
        forever begin
            @(negedge clk);
            if (wr_q.size() > 0) begin
                bus.wrValid_in = 1; bus.wrData_in = wr_q[0]; #1;
                if (bus.wrReady_out) void'(wr_q.pop_front());
            end else begin
                bus.wrValid_in = 0;
            end
        end
    end

    // Local master, read side.
    initial begin
        bus.rdReady_in = 0;
        forever begin
            @(negedge clk);
            bus.rdReady_in = rd_en; #1;
            if (bus.rdValid_out && bus.rdReady_in) begin
                if (exp_rd.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_unexpected: got %0h expected none", bus.rdData_out);
                end else begin
                    check("rd_byte", {24'd0, bus.rdData_out}, {24'd0, exp_rd.pop_front()});
                end
            end
        end
    end

    // Pulse counters.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (bus.pktEnd_out) pkt_cnt++;
            if (bus.errZero_out) zero_cnt++;
`ifdef FX2_ALIGN_CHECK_EN
            if (bus.protoErr_out) proto_cnt++;
`endif
        end
    end

    task automatic issue_cmd(input vec_t v);
        logic [7:0] d;
        mis_sel = v.missel; tail_pkt = v.pkt;
        if (v.cnt != 0) begin
            exp_out.push_back({v.rd, v.chan});
            for (int b = 3; b >= 0; b--) exp_out.push_back(v.cnt[8*b +: 8]);
            for (int i = 0; i < int'(v.cnt); i++) begin
                d = v.base + 8'(i) * v.step;
                if (v.rd) begin in_src.push_back(d); exp_rd.push_back(d); end
                else begin wr_q.push_back(d); exp_out.push_back(d); end
            end
        end
        @(negedge clk);
        bus.cmdValid_in = 1; bus.cmdIsRead_in = v.rd; bus.cmdChan_in = v.chan; bus.cmdCount_in = v.cnt;
        #1 check("cmd_ready", {31'd0, bus.cmdReady_out}, 32'd1);
        @(posedge clk); #1;
        bus.cmdValid_in = 0;
    endtask

    task automatic finish_cmd(input vec_t v, input int pk0, input int ez0, input int pe0);
        bit done = 0;
        int exp_pe;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #2;
            if (exp_out.size() == 0 && exp_rd.size() == 0 && wr_q.size() == 0 &&
                in_src.size() == 0 && pe_state == 0 && !bus.busy_out) begin
                done = 1; break;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: got busy=%0d out=%0d rd=%0d expected idle", bus.busy_out, exp_out.size(), exp_rd.size());
            exp_out.delete(); exp_rd.delete(); wr_q.delete(); in_src.delete();
        end
        repeat (2) @(negedge clk);
        #2;
        check("busy_idle", {31'd0, bus.busy_out}, 32'd0);
        check("ready_idle", {31'd0, bus.cmdReady_out}, 32'd1);
        check("pkt_pulses", pkt_cnt - pk0, {31'd0, v.pkt});
        check("zero_pulses", zero_cnt - ez0, (v.cnt == 0) ? 32'd1 : 32'd0);
`ifdef FX2_ALIGN_CHECK_EN
        exp_pe = (v.rd && v.cnt != 0 && (((v.cnt % 512) != 0) != v.pkt)) ? 1 : 0;
`else
        exp_pe = 0;
`endif
        check("proto_pulses", proto_cnt - pe0, exp_pe);
    endtask

    task automatic run_cmd(input vec_t v);
        int pk0 = pkt_cnt, ez0 = zero_cnt, pe0 = proto_cnt;
        issue_cmd(v);
        finish_cmd(v, pk0, ez0, pe0);
    endtask

    initial begin
        int pk0, ez0, pe0;
        bit seen;
        vec_t v;
        bus.cmdValid_in = 0; bus.cmdIsRead_in = 0; bus.cmdChan_in = 0; bus.cmdCount_in = 0;
        //          rd    chan    cnt            base   step   pkt   missel
        vecs[0] = '{1'b0, 7'h05, 32'd3,        8'hA1, 8'h01, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 7'h12, 32'd2,        8'h5A, 8'h69, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 7'h33, 32'd512,      8'h00, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 7'h7F, 32'd1,        8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 7'h01, 32'd0,        8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 7'h40, 32'd512,      8'h11, 8'h07, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 7'h22, 32'h00000104, 8'h30, 8'h03, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmdReady_out}, 32'd1);
        check("rst_busy", {31'd0, bus.busy_out}, 32'd0);
        check("rst_got_data", {31'd0, bus.fx2GotData_out}, 32'd0);
        check("rst_data", {24'd0, bus.fx2Data_out}, 32'd0);
        check("rst_oe", {31'd0, bus.fx2DataOe_out}, 32'd0);
        check("rst_got_room", {31'd0, bus.fx2GotRoom_out}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rdValid_out}, 32'd0);
        check("rst_pulses", {30'd0, bus.pktEnd_out, bus.errZero_out}, 32'd0);
        rst_n = 1;

        for (int k = 0; k < 7; k++) begin
            run_cmd(vecs[k]);
            $display("vector %0d: rd=%0d chan=%0h cnt=%0d checks=%0d failures=%0d", k, vecs[k].rd, vecs[k].chan, vecs[k].cnt, n_checks, n_fail);
        end

        // Backpressure: reader stalls while a 4-byte read is in flight.
        v = '{1'b1, 7'h0A, 32'd4, 8'h10, 8'h10, 1'b0, 1'b0};
        rd_en = 0;
        pk0 = pkt_cnt; ez0 = zero_cnt; pe0 = proto_cnt;
        issue_cmd(v);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #2;
            if (in_src.size() == 3) begin seen = 1; break; end
        end
        check("bp_first_byte", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        check("bp_room_low", {31'd0, bus.fx2GotRoom_out}, 32'd0);
        check("bp_rd_valid", {31'd0, bus.rdValid_out}, 32'd1);
        check("bp_held", in_src.size(), 32'd3);
        repeat (7) @(negedge clk);
        rd_en = 1;
        finish_cmd(v, pk0, ez0, pe0);
        $display("backpressure read: checks=%0d failures=%0d", n_checks, n_fail);

        // Packet end outside a tail still pulses and raises no protocol error.
        pk0 = pkt_cnt; pe0 = proto_cnt;
        pe_state = 1;
        repeat (5) @(negedge clk);
        #2;
        check("pkt_idle_pulse", pkt_cnt - pk0, 32'd1);
        check("pkt_idle_proto", proto_cnt - pe0, 32'd0);
        $display("idle packet end: checks=%0d failures=%0d", n_checks, n_fail);

        // Payload offered while idle is not accepted.
        wr_q.push_back(8'h55);
        repeat (4) @(negedge clk);
        #2;
        check("extra_wr_held", wr_q.size(), 32'd1);
        check("extra_wr_ready", {31'd0, bus.wrReady_out}, 32'd0);
        wr_q.delete();
        $display("idle payload: checks=%0d failures=%0d", n_checks, n_fail);

        // Reset after the first of three payload bytes.
        issue_cmd(vecs[0]);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #2;
            if (exp_out.size() == 2) begin seen = 1; break; end
        end
        check("mid_first_byte", {31'd0, seen}, 32'd1);
        @(posedge clk); #3;
        rst_n = 0; #1;
        check("mid_rst_ready", {31'd0, bus.cmdReady_out}, 32'd1);
        check("mid_rst_busy", {31'd0, bus.busy_out}, 32'd0);
        check("mid_rst_got_data", {31'd0, bus.fx2GotData_out}, 32'd0);
        check("mid_rst_data", {24'd0, bus.fx2Data_out}, 32'd0);
        check("mid_rst_wr_ready", {31'd0, bus.wrReady_out}, 32'd0);
        exp_out.delete(); wr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_cmd(vecs[6]);
        $display("reset mid-send then write: checks=%0d failures=%0d", n_checks, n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
